// File: rtl/card_sum_judge.sv
// Multi-channel card-sum judge: keeps one running hand per channel and scores each card.
// A hand ends on a win (stand window) or a loss (bust). Results are reported one cycle after the card.
module card_sum_judge #(
    parameter int NUM_CH   = 4,
    parameter int CARD_W   = 4,
    parameter int SUM_W    = 5,
    parameter int FACE_CAP = 10,
    parameter int STAND_TH = 17,
    parameter int BUST_TH  = 21,
    parameter int ACE_SOFT = 1,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [CARD_W-1:0] card,
    input  logic              clr,
    input  logic [CH_W-1:0]   clr_ch,
    output logic              out_valid,
    output logic [CH_W-1:0]   out_ch,
    output logic [SUM_W-1:0]  sum,
    output logic              done,
    output logic              win,
    output logic              lose,
    output logic              err
);

    // Arithmetic width: one spare bit above the sum, wide enough for any card and for the value 11.
    localparam int AW0   = (SUM_W + 1 > CARD_W + 1) ? SUM_W + 1 : CARD_W + 1;
    localparam int AW    = (AW0 > 5) ? AW0 : 5;
    localparam int CH_W1 = CH_W + 1;

    localparam logic [AW-1:0]    L_CAP    = AW'(FACE_CAP);
    localparam logic [AW-1:0]    L_STAND  = AW'(STAND_TH);
    localparam logic [AW-1:0]    L_BUST   = AW'(BUST_TH);
    localparam logic [AW-1:0]    L_ELEVEN = AW'(11);
    localparam logic [AW-1:0]    L_TEN    = AW'(10);
    localparam logic [CH_W1-1:0] L_NCH    = CH_W1'(NUM_CH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } ch_state_t;

    ch_state_t        r_state [NUM_CH];
    logic [SUM_W-1:0] r_sum   [NUM_CH];
    logic             r_soft  [NUM_CH];

    logic            w_ch_ok;
    logic            w_card_ok;
    logic [CH_W-1:0] w_idx;
    logic            w_clr_hit;
    logic            w_take;
    logic            w_bad;
    logic [AW-1:0]   w_s;
    logic            w_f_old;
    logic [AW-1:0]   w_card;
    logic [AW-1:0]   w_capped;
    logic            w_ace_soft;
    logic [AW-1:0]   w_v;
    logic            w_f;
    logic [AW-1:0]   w_t0;
    logic [AW-1:0]   w_t;
    logic            w_f_new;
    logic            w_lose;
    logic            w_win;
    logic            w_done;

    // Card qualification and scoring against the addressed channel's current hand.
    always_comb begin
        w_ch_ok    = ({1'b0, in_ch} < L_NCH);
        w_card_ok  = (card != '0);
        w_idx      = w_ch_ok ? in_ch : '0;
        w_clr_hit  = clr && (clr_ch == in_ch);
        w_take     = in_valid && w_card_ok && w_ch_ok && !w_clr_hit;
        w_bad      = in_valid && !(w_card_ok && w_ch_ok);

        w_s        = (r_state[w_idx] == ST_PLAY) ? AW'(r_sum[w_idx]) : '0;
        w_f_old    = r_soft[w_idx];
        w_card     = AW'(card);
        w_capped   = (w_card > L_CAP) ? L_CAP : w_card;
        w_ace_soft = (ACE_SOFT != 0) && (card == CARD_W'(1)) && !w_f_old
                     && ((w_s + L_ELEVEN) <= L_BUST);
        w_v        = w_ace_soft ? L_ELEVEN : w_capped;
        w_f        = w_f_old || w_ace_soft;
        w_t0       = w_s + w_v;

        // A soft ace drops back to 1 rather than letting the hand bust.
        if ((w_t0 > L_BUST) && w_f) begin
            w_t     = w_t0 - L_TEN;
            w_f_new = 1'b0;
        end else begin
            w_t     = w_t0;
            w_f_new = w_f;
        end

        w_lose = (w_t > L_BUST);
        w_win  = !w_lose && (w_t >= L_STAND);
        w_done = w_lose || w_win;
    end

    // Registered report outputs and per-channel hand state; clear beats a card on the same channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            sum       <= '0;
            done      <= 1'b0;
            win       <= 1'b0;
            lose      <= 1'b0;
            err       <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i] <= ST_IDLE;
                r_sum[i]   <= '0;
                r_soft[i]  <= 1'b0;
            end
        end else begin
            out_valid <= w_take;
            err       <= w_bad;
            done      <= w_take && w_done;
            win       <= w_take && w_win;
            lose      <= w_take && w_lose;
            if (w_take) begin
                out_ch <= in_ch;
                sum    <= w_t[SUM_W-1:0];
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (clr && (clr_ch == CH_W'(i))) begin
                    r_state[i] <= ST_IDLE;
                    r_sum[i]   <= '0;
                    r_soft[i]  <= 1'b0;
                end else if (w_take && (in_ch == CH_W'(i))) begin
                    if (w_done) begin
                        r_state[i] <= ST_IDLE;
                        r_sum[i]   <= '0;
                        r_soft[i]  <= 1'b0;
                    end else begin
                        r_state[i] <= ST_PLAY;
                        r_sum[i]   <= w_t[SUM_W-1:0];
                        r_soft[i]  <= w_f_new;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_card_sum_judge.sv
// Bench: two instances (hard aces / 4 channels, soft aces / 3 channels) share one stimulus stream;
// a per-instance reference model pushes the expected next-cycle outputs into a scoreboard queue.
module tb_card_sum_judge;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [1:0] in_ch;
    logic [3:0] card;
    logic       clr;
    logic [1:0] clr_ch;

    logic       ov_a, dn_a, wn_a, ls_a, er_a;
    logic [1:0] och_a;
    logic [4:0] sum_a;
    logic       ov_b, dn_b, wn_b, ls_b, er_b;
    logic [1:0] och_b;
    logic [4:0] sum_b;

    card_sum_judge #(.NUM_CH(4), .ACE_SOFT(0)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ch(in_ch), .card(card),
        .clr(clr), .clr_ch(clr_ch), .out_valid(ov_a), .out_ch(och_a), .sum(sum_a),
        .done(dn_a), .win(wn_a), .lose(ls_a), .err(er_a)
    );

    card_sum_judge #(.NUM_CH(3), .ACE_SOFT(1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ch(in_ch), .card(card),
        .clr(clr), .clr_ch(clr_ch), .out_valid(ov_b), .out_ch(och_b), .sum(sum_b),
        .done(dn_b), .win(wn_b), .lose(ls_b), .err(er_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [11:0] obs_a = {ov_a, och_a, sum_a, dn_a, wn_a, ls_a, er_a};
    wire [11:0] obs_b = {ov_b, och_b, sum_b, dn_b, wn_b, ls_b, er_b};

    int  checks = 0;
    int  errors = 0;
    int  ncyc   = 0;
    logic [23:0] sb_q [$];

    int  ms   [2][4];
    bit  mf   [2][4];
    int  lch  [2];
    int  lsum [2];

    // Reference model of one instance for the inputs sampled at the current edge.
    task automatic model(input int k, input int nch, input bit ace, output logic [11:0] e);
        int s, v, t, c, ch;
        bit f, acc, take, bad, dn, wn, ls;
        dn = 1'b0; wn = 1'b0; ls = 1'b0;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                ms[k][i] = 0;
                mf[k][i] = 1'b0;
            end
            lch[k] = 0;
            lsum[k] = 0;
            e = '0;
        end else begin
            c    = int'(card);
            ch   = int'(in_ch);
            acc  = in_valid && (c != 0) && (ch < nch);
            bad  = in_valid && ((c == 0) || (ch >= nch));
            take = acc && !(clr && (clr_ch == in_ch));
            if (take) begin
                s = ms[k][ch];
                f = mf[k][ch];
                v = (c > 10) ? 10 : c;
                if (ace && (c == 1) && !f && (s + 11 <= 21)) begin
                    v = 11;
                    f = 1'b1;
                end
                t = s + v;
                if ((t > 21) && f) begin
                    t = t - 10;
                    f = 1'b0;
                end
                ls = (t > 21);
                wn = !ls && (t >= 17);
                dn = ls || wn;
                ms[k][ch] = dn ? 0 : t;
                mf[k][ch] = dn ? 1'b0 : f;
                lch[k]  = ch;
                lsum[k] = t;
            end
            if (clr && (int'(clr_ch) < nch)) begin
                ms[k][clr_ch] = 0;
                mf[k][clr_ch] = 1'b0;
            end
            e = {take, 2'(lch[k]), 5'(lsum[k]), dn, wn, ls, bad};
        end
    endtask

    // Drive one cycle of inputs, then record what both instances must show after this edge.
    task automatic cyc(input bit r, input bit v, input int ch, input int cd, input bit c, input int cc);
        logic [11:0] ea, eb;
        rst = r; in_valid = v; in_ch = 2'(ch); card = 4'(cd); clr = c; clr_ch = 2'(cc);
        @(posedge clk);
        model(0, 4, 1'b0, ea);
        model(1, 3, 1'b1, eb);
        sb_q.push_back({ea, eb});
        #1;
    endtask

    task automatic play(input int ch, input int cd);
        cyc(1'b0, 1'b1, ch, cd, 1'b0, 0);
    endtask

    // Scoreboard: one expected entry per clocked cycle, compared mid-cycle.
    always @(negedge clk) begin
        logic [23:0] e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            ncyc++;
            checks++;
            assert (obs_a === e[23:12]) else begin
                errors++;
                $error("FAIL dut_a cycle %0d: observed %h expected %h", ncyc, obs_a, e[23:12]);
            end
            checks++;
            assert (obs_b === e[11:0]) else begin
                errors++;
                $error("FAIL dut_b cycle %0d: observed %h expected %h", ncyc, obs_b, e[11:0]);
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_ch = 2'd0; card = 4'd0; clr = 1'b0; clr_ch = 2'd0;
        cyc(1'b1, 1'b0, 0, 0, 1'b0, 0);
        cyc(1'b1, 1'b0, 0, 0, 1'b0, 0);
        cyc(1'b0, 1'b0, 0, 0, 1'b0, 0);
        play(0, 10); play(0, 6); play(0, 1); play(0, 5);
        cyc(1'b0, 1'b0, 0, 0, 1'b1, 0);
        play(1, 12); play(1, 13); play(1, 5); play(1, 9); play(1, 9);
        play(2, 1); play(2, 5); play(2, 9); play(2, 2);
        play(0, 8); play(3, 9); play(0, 9); play(3, 9);
        cyc(1'b0, 1'b0, 0, 0, 1'b0, 0);
        play(1, 9); play(1, 5);
        cyc(1'b0, 1'b1, 1, 5, 1'b1, 1);
        play(1, 3);
        play(2, 7); play(2, 0); play(3, 5); play(2, 3);
        cyc(1'b0, 1'b1, 0, 4, 1'b1, 2);
        play(2, 2);
        play(0, 8);
        cyc(1'b1, 1'b1, 0, 5, 1'b0, 0);
        play(0, 4);
        play(1, 1); play(1, 1); play(1, 15); play(1, 1); play(1, 15);
        cyc(1'b0, 1'b0, 0, 0, 1'b0, 0);
        cyc(1'b0, 1'b0, 0, 0, 1'b0, 0);
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(63) == 0), ($urandom_range(3) != 0), int'($urandom_range(3)),
                int'($urandom_range(15)), ($urandom_range(7) == 0), int'($urandom_range(3)));
        end
        cyc(1'b0, 1'b0, 0, 0, 1'b0, 0);
        cyc(1'b0, 1'b0, 0, 0, 1'b0, 0);
        @(negedge clk);
        #1;
        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/card_sum_judge.md
Name: card_sum_judge

Overview:
- Multi-channel, parametrised successor of the single-player card-sum game block. It keeps an independent running hand per channel (player seat) and scores each card as it arrives.
- Each hand ends on reaching the stand window (win) or exceeding the bust threshold (lose). The hand clears in the same cycle it ends, so the next card on that channel starts a fresh hand.
- Optional soft-ace scoring and a per-channel clear input. Sits between the card-dealing front end and the score/statistics logic.

Parameters:
- NUM_CH, 4, number of independent channels (≥1); CH_W = max(1, clog2(NUM_CH)).
- CARD_W, 4, card input width; card value 1..2^CARD_W-1, ace = 1.
- SUM_W, 5, running-sum width; must satisfy 2^SUM_W-1 ≥ STAND_TH-1+max(FACE_CAP,11).
- FACE_CAP, 10, cards above this value score FACE_CAP.
- STAND_TH, 17, final sum ≥ STAND_TH and ≤ BUST_TH is a win.
- BUST_TH, 21, final sum > BUST_TH is a loss.
- ACE_SOFT, 1, 1 = ace may count 11 (soft); 0 = ace always 1.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  card present this cycle.
- in_ch  in  CH_W  channel the card belongs to.
- card  in  CARD_W  card face value.
- clr  in  1  clear request for channel clr_ch.
- clr_ch  in  CH_W  channel to clear.
- out_valid  out  1  one-cycle pulse per accepted card.
- out_ch  out  CH_W  channel of the reported card.
- sum  out  SUM_W  hand total after the card.
- done  out  1  hand ended with this card.
- win  out  1  done and STAND_TH ≤ sum ≤ BUST_TH.
- lose  out  1  done and sum > BUST_TH.
- err  out  1  pulse: illegal card (0) or in_ch ≥ NUM_CH.

Behaviour:
- Reset: all outputs 0. Every channel's hand sum = 0 and soft flag = 0.
- Per-channel state is two-valued: IDLE (sum 0) or PLAYING (sum > 0).
  - IDLE → PLAYING on the first accepted card that does not end the hand.
  - PLAYING → IDLE on done or clr.
- Card acceptance: in_valid=1, card≠0 and in_ch<NUM_CH. Any other in_valid cycle drops the card, leaves state unchanged, asserts err (not out_valid) one cycle later.
- Scoring of accepted card c on channel h holding sum S and soft flag F:
  - v = min(c, FACE_CAP).
  - If ACE_SOFT=1, c=1, F=0 and S+11 ≤ BUST_TH: v = 11 and F is set.
  - T = S+v.
  - If T > BUST_TH and F (before or just set): T = T-10 and F is cleared.
  - All arithmetic is unsigned at SUM_W+1 bits, so no overflow.
- Result:
  - T > BUST_TH → lose=1, done=1.
  - STAND_TH ≤ T ≤ BUST_TH → win=1, done=1.
  - Otherwise done=win=lose=0 and the hand keeps T, F.
- On done the channel's sum and F clear in the same update. The next card on that channel starts a new hand with no extra cycle.
- Latency: out_valid/out_ch/sum/done/win/lose are registered and appear exactly 1 cycle after the accepted card. One card per cycle, no backpressure.
- Between reports (out_valid=0): done/win/lose = 0; sum and out_ch hold their last value.
- Channels are fully independent; back-to-back cards on the same channel use the just-updated state, with no bubble.
- clr: the target channel's sum and F → 0 next edge, with no output pulse.
  - clr and accepted card on the same channel in the same cycle: clr wins, the card is dropped, no out_valid and no err.
  - clr and a card on different channels: both take effect.
- rst asserted mid-hand: all channels and outputs clear at that edge; any card presented in the same cycle is dropped.
- win and lose are never both 1.

Test Plan:
- rst, then ch0 cards 10,6,1 (ACE_SOFT=0) → reports: sum 10/16/17; last has done=1, win=1; next ch0 card 5 → sum 5, done=0.
- ch1 cards 12,13,5 → sum 10, 20 (done, win); then 5 → sum 5; then 9,9 → sum 14, 23 (done, lose).
- ACE_SOFT=1, ch2 cards 1,5 → sum 11, 16 (soft); then 9 → 25-10 = 15, not done; then 2 → 17, win.
- Interleaved ch0=8, ch3=9, ch0=9, ch3=9 on consecutive cycles → out_ch 0,3,0,3 with sums 8,9,17(win),18(win), 1-cycle latency each.
- ch1 holds 14; same cycle clr_ch=1 and card 5 on ch1 → no out_valid; next ch1 card 3 → sum 3.
- card=0 and in_ch=NUM_CH (NUM_CH=3) → err pulses, state untouched. rst during ch0 sum 12 → all outputs 0; next ch0 card 4 → sum 4.
